// File: rtl/alu_bool_pipe.sv
// ---------------------------------------------------------------------------
// alu_bool_pipe
//
// Pipelined boolean/compare ALU. One of eight operations is evaluated
// combinationally on the incoming operands. The result is captured into the
// first register stage when the input beat is accepted. It then travels
// through an elastic chain of STAGES registers to the consumer. A saturating
// counter records how many accepted beats carried an undefined opcode.
//
// Parameters
//   WIDTH   operand/result width, 2..64
//   STAGES  number of register stages (= latency in cycles), 1..4
//   CNT_W   width of illegal_cnt
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operand beat valid
//   in_ready     pipeline accepts a beat this cycle
//   in_a, in_b   operands (WIDTH bits)
//   in_opcode    operation select:
//                  0 AND, 1 OR, 2 NOR, 3 XNOR, 4 LE unsigned, 5 XOR,
//                  6 LE signed, 7 EQ, 8..F illegal
//   out_valid    result beat valid
//   out_ready    consumer accepts the result this cycle
//   out_result   result (compares return 0/1 in bit 0)
//   out_zero     out_result == 0
//   out_illegal  beat carried an undefined opcode
//   illegal_cnt  accepted illegal beats, saturating at all-ones
//
// Handshake: a beat transfers on a port in every cycle where valid and ready
// are both high at the rising edge. A producer that raises valid holds it and
// its data until the transfer happens. The ready signals never depend on the
// matching valid on the same side. in_ready depends on the pipeline state and
// on out_ready. out_valid comes straight from a register, so in_valid never
// reaches out_valid combinationally.
// ---------------------------------------------------------------------------
module alu_bool_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_NOR  = 4'h2;
  localparam logic [3:0] OP_XNOR = 4'h3;
  localparam logic [3:0] OP_LEU  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LES  = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;

  localparam int LAST = STAGES - 1;

  // -------------------------------------------------------------------------
  // Combinational compute
  // -------------------------------------------------------------------------
  logic             le_u;
  logic             le_s;
  logic             eq;
  logic [WIDTH-1:0] comp_res;
  logic             comp_zero;
  logic             comp_ill;

  assign le_u = (in_a <= in_b);
  assign le_s = ($signed(in_a) <= $signed(in_b));
  assign eq   = (in_a == in_b);

  always_comb begin
    comp_res = '0;
    comp_ill = 1'b0;
    case (in_opcode)
      OP_AND:  comp_res = in_a & in_b;
      OP_OR:   comp_res = in_a | in_b;
      OP_NOR:  comp_res = ~(in_a | in_b);
      OP_XNOR: comp_res = ~(in_a ^ in_b);
      OP_LEU:  comp_res = {{(WIDTH-1){1'b0}}, le_u};
      OP_XOR:  comp_res = in_a ^ in_b;
      OP_LES:  comp_res = {{(WIDTH-1){1'b0}}, le_s};
      OP_EQ:   comp_res = {{(WIDTH-1){1'b0}}, eq};
      // Undefined opcodes: result stays 0, so out_zero is also set.
      default: comp_ill = 1'b1;
    endcase
  end

  assign comp_zero = (comp_res == '0);

  // -------------------------------------------------------------------------
  // Elastic stage chain
  // -------------------------------------------------------------------------
  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_zero;
  logic [STAGES-1:0] stg_ill;
  logic [STAGES-1:0] stg_load;
  logic [WIDTH-1:0]  stg_res [STAGES];
  logic              accept;

  // A stage may load when its contents leave this cycle or when it is empty.
  // The contents leave when every stage downstream can also take a beat.
  // This reduces to a closed form: stage k can load when out_ready is high or
  // when any stage from k to the last one is empty. Writing it this way avoids
  // a combinational loop through a ripple chain.
  always_comb begin
    stg_load = '0;
    for (int k = 0; k < STAGES; k++) begin
      stg_load[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!stg_valid[j]) stg_load[k] = 1'b1;
      end
    end
  end

  assign in_ready = stg_load[0];
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      stg_zero  <= '0;
      stg_ill   <= '0;
      for (int k = 0; k < STAGES; k++) stg_res[k] <= '0;
    end else begin
      // Stage 0 is fed by the input port.
      if (stg_load[0]) begin
        stg_valid[0] <= in_valid;
      end
      if (accept) begin
        stg_res[0]  <= comp_res;
        stg_zero[0] <= comp_zero;
        stg_ill[0]  <= comp_ill;
      end
      // A loading stage takes whatever the stage before it holds. If that
      // stage is empty, the bubble moves forward. The payload is only
      // copied along with a real beat.
      for (int k = 1; k < STAGES; k++) begin
        if (stg_load[k]) begin
          stg_valid[k] <= stg_valid[k-1];
          if (stg_valid[k-1]) begin
            stg_res[k]  <= stg_res[k-1];
            stg_zero[k] <= stg_zero[k-1];
            stg_ill[k]  <= stg_ill[k-1];
          end
        end
      end
    end
  end

  assign out_valid   = stg_valid[LAST];
  assign out_result  = stg_res[LAST];
  assign out_zero    = stg_zero[LAST];
  assign out_illegal = stg_ill[LAST];

  // -------------------------------------------------------------------------
  // Illegal-opcode counter: counts when a beat is accepted, holds at all-ones
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (accept && comp_ill && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule
